// File: rtl/ysyx_25040105_mcctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : ysyx_25040105_mcctrl_pkg
// Purpose  : Shared definitions for the multi-cycle controller: state
//            enumeration, state width and the default memory timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package ysyx_25040105_mcctrl_pkg;

  localparam int STATE_W         = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_IF_REQ   = 4'd1,
    S_IF_WAIT  = 4'd2,
    S_ID       = 4'd3,
    S_EX       = 4'd4,
    S_MEM_REQ  = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8
  } state_t;

  // States in which a memory transaction is outstanding and the wait
  // timer advances.
  function automatic logic is_mem_phase(input state_t s);
    return (s inside {S_IF_REQ, S_IF_WAIT, S_MEM_REQ, S_MEM_WAIT});
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040105_mcctrl_wait_timer.sv
//------------------------------------------------------------------------------
// Module   : ysyx_25040105_wait_timer
// Purpose  : Clearable cycle counter for one memory phase. at_limit is high
//            during the LIMIT-th cycle of the phase, i.e. the last cycle in
//            which the transaction may still complete.
// Ports    : clk, rst (async, active-low), clear (restart at 0),
//            inc (count this cycle), at_limit (limit cycle flag)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ysyx_25040105_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);

  // Wide enough to hold LIMIT itself: the counter steps once more on the
  // cycle the phase is left.
  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of cycles already spent in the phase, so the
  // current cycle is the LIMIT-th one when cnt == LIMIT-1.
  assign at_limit = (cnt == CNT_W'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/ysyx_25040105_mcctrl.sv
//------------------------------------------------------------------------------
// Module   : ysyx_25040105_mcctrl
// Purpose  : Multi-cycle CPU controller sequencing fetch, decode, execute,
//            data-memory access and write-back, with per-phase memory
//            timeout and a retired-instruction counter.
// Ports    : clk, rst (async, active-low)
//            imem_req/imem_ready/imem_rvalid  - instruction memory handshake
//            dec_mem_rd/dec_mem_wr/dec_reg_wen/dec_illegal - decoder info
//            dmem_req/dmem_we/dmem_ready/dmem_rvalid - data memory handshake
//            inst_wen/rf_wen/pc_wen - datapath strobes
//            halted/fault/instret/state - status and debug
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ysyx_25040105_mcctrl
  import ysyx_25040105_mcctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic                dec_mem_rd,
  input  logic                dec_mem_wr,
  input  logic                dec_reg_wen,
  input  logic                dec_illegal,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  input  logic                dmem_rvalid,
  output logic                inst_wen,
  output logic                rf_wen,
  output logic                pc_wen,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         instret,
  output logic [STATE_W-1:0]  state
);

  state_t      state_q;
  state_t      state_d;
  logic        at_limit;
  logic        timer_clear;
  logic        timer_inc;
  logic        timeout_halt;
  logic        fault_q;
  logic [31:0] instret_q;

  // The timer restarts on entry to each request state and keeps running
  // through the matching wait state, so one budget covers a whole phase.
  assign timer_inc   = is_mem_phase(state_q);
  assign timer_clear = ((state_d == S_IF_REQ)  && (state_q != S_IF_REQ)) ||
                       ((state_d == S_MEM_REQ) && (state_q != S_MEM_REQ));

  ysyx_25040105_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .inc      (timer_inc),
    .at_limit (at_limit)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A phase completes only on rvalid; an accepted request
  // without data still counts against the budget. Completion is tested
  // before the limit so a response on the last allowed cycle wins.
  always_comb begin
    state_d      = state_q;
    timeout_halt = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_IF_REQ;
      S_IF_REQ: begin
        if (imem_ready && imem_rvalid) begin
          state_d = S_ID;
        end else if (at_limit) begin
          state_d      = S_HALT;
          timeout_halt = 1'b1;
        end else if (imem_ready) begin
          state_d = S_IF_WAIT;
        end
      end
      S_IF_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_ID;
        end else if (at_limit) begin
          state_d      = S_HALT;
          timeout_halt = 1'b1;
        end
      end
      S_ID: state_d = dec_illegal ? S_HALT : S_EX;
      S_EX: state_d = (dec_mem_rd || dec_mem_wr) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        if (dmem_ready && dmem_rvalid) begin
          state_d = S_WB;
        end else if (at_limit) begin
          state_d      = S_HALT;
          timeout_halt = 1'b1;
        end else if (dmem_ready) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_WB;
        end else if (at_limit) begin
          state_d      = S_HALT;
          timeout_halt = 1'b1;
        end
      end
      S_WB:    state_d = S_IF_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Outputs: Moore decode of the current state, except inst_wen which
  // follows the fetch response within the completing cycle.
  always_comb begin
    imem_req = 1'b0;
    inst_wen = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_wen   = 1'b0;
    pc_wen   = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_IF_REQ: begin
        imem_req = 1'b1;
        inst_wen = imem_ready && imem_rvalid;
      end
      S_IF_WAIT: inst_wen = imem_rvalid;
      S_MEM_REQ: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_wr;
      end
      S_WB: begin
        // Stores have no register result even if the decoder flags rd.
        rf_wen = dec_reg_wen && !dec_mem_wr;
        pc_wen = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      if (timeout_halt) begin
        fault_q <= 1'b1;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign fault   = fault_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

`default_nettype wire
